req_router: RTL and testbench

REQ_ROUTER -- requirements
Module: req_router

---
 rtl/req_router_if.sv | 25 ++
 rtl/req_router.sv | 114 +++++++++++
 tb/tb_req_router.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/req_router_if.sv
// rtl/req_router_if.sv - source/destination request bus between nodesets and the router
interface req_router_if #(
    parameter int NUM_SETS     = 4,
    parameter int NUM_PATHS_DW = 16
) ();
    logic [NUM_SETS-1:0]              i_src_vld;
    logic [NUM_SETS*NUM_PATHS_DW-1:0] i_src_paths;
    logic [NUM_SETS*12-1:0]           i_src_nodenum;
    logic [NUM_SETS-1:0]              o_src_ack;
    logic [NUM_SETS-1:0]              o_dst_vld;
    logic [NUM_SETS*NUM_PATHS_DW-1:0] o_dst_paths;
    logic [NUM_SETS*6-1:0]            o_dst_nodenum;
    logic [NUM_SETS-1:0]              i_dst_ack;
    logic [NUM_SETS-1:0]              i_set_complete;

    modport slave (
        input  i_src_vld, i_src_paths, i_src_nodenum, i_dst_ack, i_set_complete,
        output o_src_ack, o_dst_vld, o_dst_paths, o_dst_nodenum
    );

    modport master (
        output i_src_vld, i_src_paths, i_src_nodenum, i_dst_ack, i_set_complete,
        input  o_src_ack, o_dst_vld, o_dst_paths, o_dst_nodenum
    );
endinterface

// File: rtl/req_router.sv
// rtl/req_router.sv - round-robin crossbar from nodeset sources to one-entry destination registers
module req_router #(
    parameter int NUM_SETS     = 4,
    parameter int NUM_PATHS_DW = 16
) (
    input  logic         clk,
    input  logic         rst,
    req_router_if.slave  bus,
    output logic         o_quiescent,
    output logic         o_bad_dest
);
    localparam int SETW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    typedef logic [SETW-1:0] idx_t;

    logic [NUM_SETS-1:0]                   r_vld;
    logic [NUM_SETS-1:0][NUM_PATHS_DW-1:0] r_paths;
    logic [NUM_SETS-1:0][5:0]              r_tag;
    idx_t                                  r_rr [NUM_SETS];
    logic                                  r_idle_d;
    logic                                  r_quiescent;
    logic                                  r_bad;

    logic [NUM_SETS-1:0][5:0] w_dest;
    logic [NUM_SETS-1:0]      w_bad;
    logic [NUM_SETS-1:0]      w_req [NUM_SETS];
    logic [NUM_SETS-1:0]      w_load;
    logic [NUM_SETS-1:0]      w_grant;
    idx_t                     w_win [NUM_SETS];
    logic [NUM_SETS-1:0]      w_ack;
    logic                     w_idle;

    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            w_dest[s] = bus.i_src_nodenum[s*12+6 +: 6];
            w_bad[s]  = bus.i_src_vld[s] && ({1'b0, w_dest[s]} >= 7'(NUM_SETS));
        end
    end

    // w_req[d][s]: source s holds a legal request aimed at destination d
    always_comb begin
        for (int d = 0; d < NUM_SETS; d++) begin
            w_req[d] = '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                w_req[d][s] = bus.i_src_vld[s] && !w_bad[s] && (w_dest[s] == 6'(d));
            end
        end
    end

    // Search upward from r_rr[d]; idx_t wraps naturally since NUM_SETS is a power of two
    always_comb begin
        idx_t w_cand;
        w_cand = '0;
        for (int d = 0; d < NUM_SETS; d++) begin
            w_grant[d] = 1'b0;
            w_win[d]   = '0;
            w_load[d]  = !r_vld[d] || bus.i_dst_ack[d];
            for (int k = 0; k < NUM_SETS; k++) begin
                w_cand = r_rr[d] + idx_t'(k);
                if (!w_grant[d] && w_req[d][w_cand]) begin
                    w_grant[d] = 1'b1;
                    w_win[d]   = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_ack = w_bad;
        for (int d = 0; d < NUM_SETS; d++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (w_load[d] && w_grant[d] && (w_win[d] == idx_t'(s))) begin
                    w_ack[s] = 1'b1;
                end
            end
        end
    end

    assign w_idle = (&bus.i_set_complete) && !(|bus.i_src_vld) && !(|r_vld);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_idle_d    <= 1'b0;
            r_quiescent <= 1'b0;
            r_bad       <= 1'b0;
            for (int d = 0; d < NUM_SETS; d++) begin
                r_rr[d] <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_SETS; d++) begin
                if (w_load[d]) begin
                    r_vld[d] <= w_grant[d];
                    if (w_grant[d]) begin
                        r_paths[d] <= bus.i_src_paths[w_win[d]*NUM_PATHS_DW +: NUM_PATHS_DW];
                        r_tag[d]   <= bus.i_src_nodenum[w_win[d]*12 +: 6];
                        r_rr[d]    <= w_win[d] + idx_t'(1);
                    end
                end
            end
            if (|w_bad) begin
                r_bad <= 1'b1;
            end
            r_idle_d    <= w_idle;
            r_quiescent <= w_idle && r_idle_d;
        end
    end

    assign bus.o_src_ack     = rst ? '0 : w_ack;
    assign bus.o_dst_vld     = r_vld;
    assign bus.o_dst_paths   = r_paths;
    assign bus.o_dst_nodenum = r_tag;
    assign o_quiescent       = r_quiescent;
    assign o_bad_dest        = r_bad;
endmodule

// File: tb/tb_req_router.sv
// tb/tb_req_router.sv - directed stimulus with a per-cycle reference model for req_router
module tb_req_router;
    localparam int NS = 4;
    localparam int DW = 16;

    logic clk;
    logic rst;
    logic q;
    logic bad;
    int   n_vec  = 0;
    int   n_fail = 0;

    req_router_if #(.NUM_SETS(NS), .NUM_PATHS_DW(DW)) rif ();

    req_router #(.NUM_SETS(NS), .NUM_PATHS_DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (rif.slave),
        .o_quiescent (q),
        .o_bad_dest  (bad)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one buffered entry per destination, rotating priority per destination
    bit          m_known = 0;
    bit          m_vld [NS];
    int          m_paths [NS];
    int          m_tag [NS];
    int          m_rr [NS];
    bit          m_bad;
    bit          m_q;
    bit          m_idle_prev;
    int          dst_of [NS];
    int          win [NS];
    bit          ldok [NS];
    logic [NS-1:0] exp_ack;
    bit          any_bad;
    bit          idle;
    int          cand;

    always @(negedge clk) begin
        exp_ack = '0;
        any_bad = 0;
        for (int s = 0; s < NS; s++) begin
            dst_of[s] = int'(rif.i_src_nodenum[s*12+6 +: 6]);
            if (rif.i_src_vld[s] && dst_of[s] >= NS) begin
                exp_ack[s] = 1'b1;
                any_bad = 1;
            end
        end
        for (int d = 0; d < NS; d++) begin
            win[d] = -1;
            for (int k = 0; k < NS; k++) begin
                cand = (m_rr[d] + k) % NS;
                if (win[d] < 0 && rif.i_src_vld[cand] && dst_of[cand] == d) win[d] = cand;
            end
            ldok[d] = !m_vld[d] || rif.i_dst_ack[d];
            if (ldok[d] && win[d] >= 0) exp_ack[win[d]] = 1'b1;
        end
        if (rst) exp_ack = '0;

        check("model_src_ack", 32'(rif.o_src_ack), 32'(exp_ack));
        if (m_known) begin
            for (int d = 0; d < NS; d++) begin
                check("model_dst_vld", 32'(rif.o_dst_vld[d]), 32'(m_vld[d]));
                if (m_vld[d]) begin
                    check("model_dst_paths", 32'(rif.o_dst_paths[d*DW +: DW]), 32'(m_paths[d]));
                    check("model_dst_tag", 32'(rif.o_dst_nodenum[d*6 +: 6]), 32'(m_tag[d]));
                end
            end
            check("model_bad_dest", 32'(bad), 32'(m_bad));
            check("model_quiescent", 32'(q), 32'(m_q));
        end

        if (rst) begin
            for (int d = 0; d < NS; d++) begin
                m_vld[d] = 0;
                m_rr[d]  = 0;
            end
            m_bad = 0;
            m_q = 0;
            m_idle_prev = 0;
            m_known = 1;
        end else begin
            idle = (rif.i_set_complete == '1) && (rif.i_src_vld == '0);
            for (int d = 0; d < NS; d++) if (m_vld[d]) idle = 0;
            for (int d = 0; d < NS; d++) begin
                if (ldok[d]) begin
                    m_vld[d] = (win[d] >= 0);
                    if (win[d] >= 0) begin
                        m_paths[d] = int'(rif.i_src_paths[win[d]*DW +: DW]);
                        m_tag[d]   = int'(rif.i_src_nodenum[win[d]*12 +: 6]);
                        m_rr[d]    = (win[d] + 1) % NS;
                    end
                end
            end
            if (any_bad) m_bad = 1;
            m_q = idle && m_idle_prev;
            m_idle_prev = idle;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic src(input int s, input logic v, input logic [11:0] tag, input logic [15:0] p);
        rif.i_src_vld[s]              = v;
        rif.i_src_nodenum[s*12 +: 12] = tag;
        rif.i_src_paths[s*DW +: DW]   = p;
    endtask

    initial begin
        rst = 1'b1;
        rif.i_src_vld      = '0;
        rif.i_src_paths    = '0;
        rif.i_src_nodenum  = '0;
        rif.i_dst_ack      = '1;
        rif.i_set_complete = '1;
        repeat (2) nxt();
        rst = 1'b0;
        smp();
        check("reset_dst_vld", 32'(rif.o_dst_vld), 32'h0);
        check("reset_bad", 32'(bad), 32'h0);
        check("reset_quiescent", 32'(q), 32'h0);

        // single request to set 3
        nxt(); src(1, 1'b1, 12'h0C5, 16'd7); smp();
        check("single_ack", 32'(rif.o_src_ack), 32'b0010);
        nxt(); src(1, 1'b0, 12'h0, 16'd0); smp();
        check("single_vld", 32'(rif.o_dst_vld), 32'b1000);
        check("single_tag", 32'(rif.o_dst_nodenum[23:18]), 32'h05);
        check("single_paths", 32'(rif.o_dst_paths[63:48]), 32'd7);
        nxt(); smp();
        check("single_once", 32'(rif.o_dst_vld), 32'b0000);

        // three-way contention on set 2
        nxt();
        src(0, 1'b1, 12'h081, 16'd10);
        src(1, 1'b1, 12'h082, 16'd11);
        src(2, 1'b1, 12'h083, 16'd12);
        smp();
        check("rr_ack0", 32'(rif.o_src_ack), 32'b0001);
        nxt(); src(0, 1'b0, 12'h0, 16'd0); smp();
        check("rr_ack1", 32'(rif.o_src_ack), 32'b0010);
        check("rr_paths0", 32'(rif.o_dst_paths[47:32]), 32'd10);
        nxt(); src(1, 1'b0, 12'h0, 16'd0); smp();
        check("rr_ack2", 32'(rif.o_src_ack), 32'b0100);
        check("rr_paths1", 32'(rif.o_dst_paths[47:32]), 32'd11);
        nxt(); src(2, 1'b0, 12'h0, 16'd0); smp();
        check("rr_vld2", 32'(rif.o_dst_vld), 32'b0100);
        check("rr_paths2", 32'(rif.o_dst_paths[47:32]), 32'd12);
        check("rr_tag2", 32'(rif.o_dst_nodenum[17:12]), 32'h03);
        nxt(); smp();
        check("rr_drain", 32'(rif.o_dst_vld), 32'b0000);

        // backpressure on set 0
        nxt(); rif.i_dst_ack = 4'b1110; src(3, 1'b1, 12'h011, 16'd20); smp();
        check("bp_first_ack", 32'(rif.o_src_ack), 32'b1000);
        nxt(); src(3, 1'b1, 12'h012, 16'd21);
        for (int i = 0; i < 5; i++) begin
            smp();
            check("bp_no_ack", 32'(rif.o_src_ack), 32'b0000);
            check("bp_hold_paths", 32'(rif.o_dst_paths[15:0]), 32'd20);
            nxt();
        end
        rif.i_dst_ack = 4'b1111; smp();
        check("bp_release_ack", 32'(rif.o_src_ack), 32'b1000);
        nxt(); src(3, 1'b0, 12'h0, 16'd0); smp();
        check("bp_next_vld", 32'(rif.o_dst_vld), 32'b0001);
        check("bp_next_paths", 32'(rif.o_dst_paths[15:0]), 32'd21);
        check("bp_next_tag", 32'(rif.o_dst_nodenum[5:0]), 32'h12);
        nxt(); smp();
        check("bp_drain", 32'(rif.o_dst_vld), 32'b0000);

        // invalid destination
        nxt(); src(0, 1'b1, 12'h4FF, 16'h55); smp();
        check("bad_ack", 32'(rif.o_src_ack), 32'b0001);
        check("bad_not_yet", 32'(bad), 32'h0);
        nxt(); src(0, 1'b0, 12'h0, 16'd0); smp();
        check("bad_set", 32'(bad), 32'h1);
        check("bad_no_vld", 32'(rif.o_dst_vld), 32'b0000);
        repeat (3) nxt();
        smp();
        check("bad_sticky", 32'(bad), 32'h1);

        // quiescence, then a request that is held at set 1 for the reset case
        check("quiet_on", 32'(q), 32'h1);
        nxt(); rif.i_dst_ack = 4'b1101; src(2, 1'b1, 12'h041, 16'd5); smp();
        check("quiet_still", 32'(q), 32'h1);
        check("quiet_ack", 32'(rif.o_src_ack), 32'b0100);
        nxt(); src(2, 1'b0, 12'h0, 16'd0); smp();
        check("quiet_off", 32'(q), 32'h0);
        check("held_vld", 32'(rif.o_dst_vld), 32'b0010);

        // reset mid-burst
        nxt(); rst = 1'b1; src(0, 1'b1, 12'h045, 16'd9); smp();
        check("rst_no_ack", 32'(rif.o_src_ack), 32'b0000);
        nxt(); rst = 1'b0; src(0, 1'b0, 12'h0, 16'd0); rif.i_dst_ack = 4'b1111; smp();
        check("rst_vld_clear", 32'(rif.o_dst_vld), 32'b0000);
        check("rst_bad_clear", 32'(bad), 32'h0);
        nxt(); src(0, 1'b1, 12'h090, 16'd1); src(3, 1'b1, 12'h091, 16'd2); smp();
        check("rst_rr_zero", 32'(rif.o_src_ack), 32'b0001);
        nxt(); src(0, 1'b0, 12'h0, 16'd0); smp();
        check("rst_rr_next", 32'(rif.o_src_ack), 32'b1000);
        check("rst_paths_a", 32'(rif.o_dst_paths[47:32]), 32'd1);
        nxt(); src(3, 1'b0, 12'h0, 16'd0); smp();
        check("rst_paths_b", 32'(rif.o_dst_paths[47:32]), 32'd2);

        // mixed traffic pattern checked by the model only
        for (int i = 0; i < 96; i++) begin
            nxt();
            rif.i_dst_ack      = 4'((i * 3 + 1) % 16);
            rif.i_set_complete = (i % 11 == 0) ? 4'b0111 : 4'b1111;
            for (int s = 0; s < NS; s++) begin
                src(s, 1'(((i * 7 + s * 5) % 3) != 0),
                    12'({6'((i + s) % 5), 6'(i * 4 + s)}),
                    16'(i * 16 + s));
            end
        end
        nxt();
        rif.i_src_vld = '0;
        rif.i_dst_ack = '1;
        rif.i_set_complete = '1;
        repeat (6) nxt();
        smp();
        check("end_drained", 32'(rif.o_dst_vld), 32'b0000);
        check("end_quiet", 32'(q), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
